// File: rtl/cb_pkg.sv
// Shared constants, state encoding and CRC-24B step
// for the code block segmentation/desegmentation pair.
package cb_pkg;

  localparam int LARGE_BYTES = 768;
  localparam int SMALL_BYTES = 132;
  localparam int CRC_BYTES   = 3;

  localparam logic [23:0] CRC24B_POLY = 24'h800063;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DATA,
    CRC,
    CHECK
  } state_t;

  function automatic logic [23:0] crc24b_upd(
    input logic [23:0] c,
    input logic [7:0]  b
  );
    logic [23:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[23] ^ b[i])
        r = {r[22:0], 1'b0} ^ CRC24B_POLY;
      else
        r = {r[22:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/cb_desegment_if.sv
// Byte-serial code block input and reassembled
// transport block write-request output.
interface cb_desegment_if;

  logic       cb_start;
  logic       cb_size;
  logic [5:0] cb_filler;
  logic       cb_crc_en;
  logic       cb_last;
  logic [7:0] cb_data;
  logic       cb_valid;
  logic       cb_ready;
  logic       tb_full;
  logic [7:0] tb_data;
  logic       tb_wreq;
  logic       tb_first;
  logic       tb_last;
  logic       crc_done;
  logic       crc_ok;
  logic       tb_err;
  logic       proto_err;

  modport slave (
    input  cb_start, cb_size, cb_filler,
    input  cb_crc_en, cb_last, cb_data,
    input  cb_valid, tb_full,
    output cb_ready, tb_data, tb_wreq,
    output tb_first, tb_last, crc_done,
    output crc_ok, tb_err, proto_err
  );

  modport master (
    output cb_start, cb_size, cb_filler,
    output cb_crc_en, cb_last, cb_data,
    output cb_valid, tb_full,
    input  cb_ready, tb_data, tb_wreq,
    input  tb_first, tb_last, crc_done,
    input  crc_ok, tb_err, proto_err
  );

endinterface

// File: rtl/crc24b_byte.sv
// Byte-wide CRC-24B accumulator, init 0, MSB first.
// Shared with the segmentation encoder.
module crc24b_byte
  import cb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [23:0] crc
);

  logic [23:0] base;

  assign base = clear ? '0 : crc;

  // clear restarts from zero; a coincident byte folds in on top
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      crc <= '0;
    else if (en)
      crc <= crc24b_upd(base, data);
    else if (clear)
      crc <= '0;
  end

endmodule

// File: rtl/cb_desegment.sv
// Strips filler and CB CRCs from a code block stream,
// rebuilds the TB byte stream and checks each CB CRC.
module cb_desegment
  import cb_pkg::*;
(
  input logic       clk,
  input logic       reset,
  cb_desegment_if.slave bus
);

  state_t      st, nst;
  logic [9:0]  cnt, ncnt;
  logic [9:0]  fill_r, pay_r;
  logic        crcen_r, last_r;
  logic [23:0] rx, crc;
  logic        next_first, cur_first;

  logic        xfer, hdr, busy;
  logic [9:0]  h_len, h_fill, h_pay;
  logic        h_bad, proto, chk_fail;
  state_t      e_st;
  logic [9:0]  e_cnt, e_fill, e_pay;
  logic        e_crcen, e_last, first_now;
  logic        fwd, fin, feed, rx_en;

  assign bus.cb_ready = ~bus.tb_full;

  assign xfer  = bus.cb_valid & ~bus.tb_full;
  assign hdr   = xfer & bus.cb_start;
  assign busy  = (st == FILL) || (st == DATA) ||
                 (st == CRC);

  assign h_len  = bus.cb_size ? 10'(LARGE_BYTES)
                              : 10'(SMALL_BYTES);
  assign h_fill = {4'd0, bus.cb_filler};
  assign h_pay  = h_len - h_fill -
                  (bus.cb_crc_en ? 10'(CRC_BYTES) : 10'd0);
  assign h_bad  = h_fill > (h_len - 10'(CRC_BYTES));

  // CHECK lasts one cycle and accepts a back-to-back header
  // like IDLE, so consecutive CBs are not flagged.
  assign proto = (hdr & busy) | (hdr & h_bad) |
                 (xfer & ~bus.cb_start & ~busy);

  assign chk_fail = (st == CHECK) && (rx != crc);

  // a header byte is processed as byte 0 of its first state
  assign e_st    = hdr ? (h_bad ? IDLE :
                   (h_fill != 0 ? FILL : DATA)) : st;
  assign e_cnt   = hdr ? 10'd0 : cnt;
  assign e_fill  = hdr ? h_fill : fill_r;
  assign e_pay   = hdr ? h_pay : pay_r;
  assign e_crcen = hdr ? bus.cb_crc_en : crcen_r;
  assign e_last  = hdr ? bus.cb_last : last_r;

  assign first_now = hdr ? next_first : cur_first;

  // next state, counter and per-byte actions
  always_comb begin
    nst   = (st == CHECK) ? IDLE : st;
    ncnt  = cnt;
    fwd   = 1'b0;
    fin   = 1'b0;
    feed  = 1'b0;
    rx_en = 1'b0;
    if (hdr) begin
      nst  = e_st;
      ncnt = '0;
    end
    unique case (1'b1)
      xfer && (e_st == FILL): begin
        feed = 1'b1;
        if (e_cnt == e_fill - 10'd1) begin
          nst  = DATA;
          ncnt = '0;
        end else begin
          ncnt = e_cnt + 10'd1;
        end
      end
      xfer && (e_st == DATA): begin
        feed = 1'b1;
        fwd  = 1'b1;
        if (e_cnt == e_pay - 10'd1) begin
          fin  = 1'b1;
          nst  = e_crcen ? CRC : IDLE;
          ncnt = '0;
        end else begin
          ncnt = e_cnt + 10'd1;
        end
      end
      xfer && (e_st == CRC): begin
        rx_en = 1'b1;
        if (e_cnt == 10'd2) begin
          nst  = CHECK;
          ncnt = '0;
        end else begin
          ncnt = e_cnt + 10'd1;
        end
      end
      default: ;
    endcase
  end

  crc24b_byte u_crc (
    .clk   (clk),
    .reset (reset),
    .clear (hdr),
    .en    (feed),
    .data  (bus.cb_data),
    .crc   (crc)
  );

  // state, header latches and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= IDLE;
      cnt           <= '0;
      fill_r        <= '0;
      pay_r         <= '0;
      crcen_r       <= 1'b0;
      last_r        <= 1'b0;
      rx            <= '0;
      next_first    <= 1'b1;
      cur_first     <= 1'b0;
      bus.tb_data   <= '0;
      bus.tb_wreq   <= 1'b0;
      bus.tb_first  <= 1'b0;
      bus.tb_last   <= 1'b0;
      bus.crc_done  <= 1'b0;
      bus.crc_ok    <= 1'b0;
      bus.tb_err    <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      st  <= nst;
      cnt <= ncnt;
      if (hdr) begin
        fill_r     <= h_fill;
        pay_r      <= h_pay;
        crcen_r    <= bus.cb_crc_en;
        last_r     <= bus.cb_last;
        next_first <= bus.cb_last;
      end
      cur_first <= first_now & ~fwd;
      if (rx_en)
        rx <= {rx[15:0], bus.cb_data};
      if (fwd)
        bus.tb_data <= bus.cb_data;
      bus.tb_wreq   <= fwd;
      bus.tb_first  <= fwd & first_now;
      bus.tb_last   <= fin & e_last;
      bus.crc_done  <= (st == CHECK);
      bus.crc_ok    <= (st == CHECK) && (rx == crc);
      bus.proto_err <= proto;
      bus.tb_err    <= proto | chk_fail |
                       (bus.tb_err & ~(hdr & next_first));
    end
  end

endmodule

// File: tb/tb_cb_desegment.sv
// Directed bench for cb_desegment: multi-CB TBs,
// CRC errors, stalls, header aborts and reset.
module tb_cb_desegment;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cb_desegment_if bus ();

  cb_desegment dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         first_pos[$];
  int         last_pos[$];
  int         ok_q[$];
  int         perr = 0;
  int         viol = 0;
  logic       full_q = 1'b0;

  always @(posedge clk) full_q <= bus.tb_full;

  always @(negedge clk) begin
    if (bus.tb_wreq === 1'b1) begin
      got.push_back(bus.tb_data);
      if (bus.tb_first === 1'b1)
        first_pos.push_back(got.size() - 1);
      if (bus.tb_last === 1'b1)
        last_pos.push_back(got.size() - 1);
      if (full_q === 1'b1)
        viol++;
    end
    if (bus.crc_done === 1'b1)
      ok_q.push_back(int'(bus.crc_ok));
    if (bus.proto_err === 1'b1)
      perr++;
  end

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic int head(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic logic [23:0] crc_model(
    input logic [23:0] c,
    input logic [7:0]  b
  );
    logic [23:0] r;
    logic        fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[23] ^ b[k];
      r  = r << 1;
      if (fb) r = r ^ 24'h800063;
    end
    return r;
  endfunction

  function automatic logic [7:0] pat(input int seed,
                                     input int i);
    return 8'(seed + i * 13 + (i >> 4));
  endfunction

  task automatic clr_mon();
    got.delete();
    exp_q.delete();
    first_pos.delete();
    last_pos.delete();
    ok_q.delete();
    perr = 0;
    viol = 0;
  endtask

  task automatic drive_byte(input logic [7:0] b,
                            input bit s,
                            input bit gap,
                            input bit stall);
    bus.cb_data  = b;
    bus.cb_start = s;
    bus.cb_valid = 1'b1;
    if (stall) begin
      bus.tb_full = 1'b1;
      repeat (10) @(posedge clk);
      #1 bus.tb_full = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.cb_valid = 1'b0;
    bus.cb_start = 1'b0;
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cb(input bit sz, input int fil,
                         input bit ce, input bit lst,
                         input int seed,
                         input logic [7:0] flip,
                         input int limit,
                         input int stall_at,
                         input bit gap);
    int          len, pay, k;
    logic [23:0] c;
    logic [7:0]  b;
    len = sz ? 768 : 132;
    pay = len - fil - (ce ? 3 : 0);
    c   = '0;
    bus.cb_size   = sz;
    bus.cb_filler = 6'(fil);
    bus.cb_crc_en = ce;
    bus.cb_last   = lst;
    for (int i = 0; i < len && i < limit; i++) begin
      if (i < fil) begin
        b = 8'h00;
        c = crc_model(c, b);
      end else if (i < fil + pay) begin
        b = pat(seed, i - fil);
        c = crc_model(c, b);
        exp_q.push_back(b);
      end else begin
        k = i - fil - pay;
        if (k == 0)      b = c[23:16];
        else if (k == 1) b = c[15:8];
        else             b = c[7:0] ^ flip;
      end
      drive_byte(b, i == 0, gap, i == stall_at);
    end
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag,
                              input int n);
    int bad;
    bad = 0;
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < got.size(); i++)
      if (i >= exp_q.size() || got[i] !== exp_q[i])
        bad++;
    check({tag, "_data_bad"}, bad, 0);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_outs"},
          int'({bus.tb_wreq, bus.tb_first,
                bus.tb_last, bus.crc_done,
                bus.crc_ok, bus.tb_err,
                bus.proto_err}), 0);
    check({tag, "_data"}, int'(bus.tb_data), 0);
    check({tag, "_ready"}, int'(bus.cb_ready), 1);
  endtask

  task automatic run_s1(input logic [7:0] flip,
                        input int stall_at,
                        input bit gap);
    send_cb(1'b1, 4, 1'b1, 1'b0, 17, flip,
            10000, stall_at, gap);
    send_cb(1'b0, 0, 1'b1, 1'b1, 91, 8'h00,
            10000, -1, gap);
    drain();
  endtask

  task automatic run_s2(input string tag);
    send_cb(1'b0, 0, 1'b0, 1'b1, 55, 8'h00,
            10000, -1, 1'b0);
    drain();
    check_stream(tag, 132);
    check({tag, "_first"}, head(first_pos), 0);
    check({tag, "_last"}, head(last_pos), 131);
    check({tag, "_ndone"}, ok_q.size(), 0);
  endtask

  initial begin
    bus.cb_start  = 1'b0;
    bus.cb_size   = 1'b0;
    bus.cb_filler = '0;
    bus.cb_crc_en = 1'b0;
    bus.cb_last   = 1'b0;
    bus.cb_data   = '0;
    bus.cb_valid  = 1'b0;
    bus.tb_full   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outs("rst");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    clr_mon();
    run_s1(8'h00, -1, 1'b0);
    check_stream("s1", 890);
    check("s1_first", head(first_pos), 0);
    check("s1_nfirst", first_pos.size(), 1);
    check("s1_last", head(last_pos), 889);
    check("s1_ndone", ok_q.size(), 2);
    check("s1_ok", ok_q.size() == 2 ?
          ok_q[0] + ok_q[1] : -1, 2);
    check("s1_err", int'(bus.tb_err), 0);
    check("s1_perr", perr, 0);

    clr_mon();
    run_s2("s2");
    check("s2_err", int'(bus.tb_err), 0);

    clr_mon();
    run_s1(8'h01, -1, 1'b0);
    check_stream("s3", 890);
    check("s3_ndone", ok_q.size(), 2);
    check("s3_ok0", head(ok_q), 0);
    check("s3_ok1", ok_q.size() == 2 ?
          ok_q[1] : -1, 1);
    check("s3_err", int'(bus.tb_err), 1);
    repeat (5) @(posedge clk);
    #1;
    check("s3_err_hold", int'(bus.tb_err), 1);

    clr_mon();
    run_s2("s3b");
    check("s3b_err_clr", int'(bus.tb_err), 0);

    clr_mon();
    run_s1(8'h00, 200, 1'b1);
    check_stream("s4", 890);
    check("s4_stall_wreq", viol, 0);
    check("s4_ndone", ok_q.size(), 2);
    check("s4_first", head(first_pos), 0);
    check("s4_last", head(last_pos), 889);
    check("s4_err", int'(bus.tb_err), 0);

    clr_mon();
    send_cb(1'b1, 0, 1'b1, 1'b0, 33, 8'h00,
            300, -1, 1'b0);
    send_cb(1'b0, 0, 1'b1, 1'b1, 77, 8'h00,
            10000, -1, 1'b0);
    drain();
    check_stream("s5", 429);
    check("s5_perr", perr, 1);
    check("s5_err", int'(bus.tb_err), 1);
    check("s5_ndone", ok_q.size(), 1);
    check("s5_ok", head(ok_q), 1);
    check("s5_first", head(first_pos), 0);
    check("s5_last", head(last_pos), 428);

    clr_mon();
    send_cb(1'b1, 0, 1'b1, 1'b1, 5, 8'h00,
            400, -1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outs("s6_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    clr_mon();
    run_s2("s6");
    check("s6_err", int'(bus.tb_err), 0);
    check("s6_perr", perr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cb_desegment.md
Name: cb_desegment

Overview:
- Receive-side inverse of code block segmentation.
- Accepts a byte-serial stream of code blocks in the same byte format the segmentation block emits: large or small size, leading filler bytes, trailing 24-bit CB CRC when the TB has more than one CB.
- Strips the filler bytes and CB CRCs and writes the reassembled transport block bytes into a downstream buffer through a write-request interface.
- Checks each CB CRC (CRC-24B) and reports pass/fail per CB and per TB.

Parameters:
- LARGE_BYTES, 768, length in bytes of a large CB (6144 bits).
- SMALL_BYTES, 132, length in bytes of a small CB (1056 bits).
- CRC_BYTES, 3, length of the CB CRC field in bytes.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cb_start  in  1  one-cycle pulse coincident with the first byte of a CB; qualifies the header inputs
- cb_size  in  1  1 = large CB, 0 = small CB; sampled with cb_start
- cb_filler  in  6  number of leading filler bytes (0..63); sampled with cb_start
- cb_crc_en  in  1  1 = CB carries a trailing CB CRC; sampled with cb_start
- cb_last  in  1  1 = last CB of the TB; sampled with cb_start
- cb_data  in  8  CB byte
- cb_valid  in  1  cb_data is valid; gaps allowed
- cb_ready  out  1  = ~tb_full; a byte transfers when cb_valid & cb_ready
- tb_full  in  1  downstream buffer full
- tb_data  out  8  reassembled TB byte
- tb_wreq  out  1  write request for tb_data
- tb_first  out  1  marks the first TB byte
- tb_last  out  1  marks the final TB byte
- crc_done  out  1  one-cycle pulse at the end of each CB with crc_en=1
- crc_ok  out  1  CB CRC result; valid with crc_done
- tb_err  out  1  sticky; any CRC fail or protocol error in the current TB; cleared on the next TB's first cb_start
- proto_err  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (asynchronous): FSM goes to IDLE. All outputs are 0 except cb_ready, which follows ~tb_full. The CRC register and the counter clear.
- Byte transfer: a byte transfers only when cb_valid & cb_ready. When no transfer occurs, state, counter and CRC hold.
- Header: cb_start is valid only together with a transferring first byte. On that transfer the block latches size, filler, crc_en and last.
  - len = LARGE_BYTES or SMALL_BYTES, selected by size.
  - payload = len - filler - (crc_en ? 3 : 0), computed in 10-bit unsigned arithmetic.
  - filler > len - 3 is a protocol error.
- FSM states: IDLE, FILL, DATA, CRC, CHECK. All byte counts below are transfer counts.
  - IDLE: on cb_start, go to FILL if filler > 0, else DATA. The first byte is consumed by whichever state is entered: filler is dropped, data is forwarded.
  - FILL: drop filler bytes. Filler bytes still feed the CRC; they are zeros. After `filler` bytes, go to DATA.
  - DATA: forward `payload` bytes and feed each into the CRC. After the last payload byte, go to CRC if crc_en, else IDLE.
  - CRC: shift in 3 received CRC bytes, MSB first. Do not forward them. After the third byte, go to CHECK.
  - CHECK: one cycle. Compare the received CRC with the computed CRC. Pulse crc_done and drive crc_ok. If the comparison fails, set tb_err. Go to IDLE.
- CRC computation: CRC-24B, polynomial 0x800063, init 0, MSB-first, processed one byte per transfer.
- Output timing: outputs are registered, one cycle after the transfer.
  - tb_wreq=1 for each forwarded byte.
  - tb_first goes with the first forwarded byte after a cb_start that follows a cb_last=1 CB, or after reset.
  - tb_last goes with the final payload byte of a CB with last=1.
- Protocol errors, each pulses proto_err and sets tb_err:
  - cb_start while not in IDLE: abort the current CB and treat the byte as a new header; restart the CRC and counter.
  - A byte in IDLE without cb_start: drop it.
- Reset mid-CB: partial output is abandoned. The next cb_start is treated as a TB start.
- tb_full asserted mid-CB: stall with no loss. While stalled, CHECK still completes.

Decomposition:
- Shared package (cb_pkg), shared with the segmentation side:
  - LARGE_BYTES, SMALL_BYTES, CRC_BYTES
  - CRC24B polynomial
  - FSM state encoding
- Sub-module crc24b_byte:
  - Inputs: clk, reset, clear, en, byte.
  - Output: 24-bit CRC.
  - Reused by the segmentation encoder.

Test Plan:
1. Two-CB TB. CB0: large, filler=4, crc_en=1, last=0. CB1: small, filler=0, crc_en=1, last=1. Valid CRCs. -> 761 + 129 = 890 tb_wreq; tb_first on byte 0; tb_last on byte 889; two crc_done with crc_ok=1; tb_err=0.
2. Single small CB, crc_en=0, filler=0, last=1 -> 132 bytes forwarded; no crc_done; tb_first and tb_last on bytes 0 and 131.
3. Scenario 1 with bit 0 of CB0 CRC byte 2 flipped -> CB0 crc_ok=0; tb_err=1 until the next TB's cb_start; CB1 crc_ok=1.
4. tb_full held high for 10 cycles mid-DATA and cb_valid toggled every other cycle -> output byte sequence identical to scenario 1; no tb_wreq while tb_full=1.
5. cb_start reasserted at CB byte 300 -> proto_err pulse; tb_err=1; the new CB is processed correctly from that byte.
6. reset pulsed at byte 400 of a large CB, then a clean scenario 2 -> all outputs 0 during reset; scenario 2 result is exact.
